// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - reads COUNT words from a 2-cycle-latency BRAM and streams them out
// with a last flag; a credit-limited skid FIFO absorbs downstream backpressure.
module bram_stream_reader #(
    parameter int RAM_WIDTH    = 18,
    parameter int RAM_DEPTH    = 1024,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4,
    localparam int ADDR_W      = $clog2(RAM_DEPTH),
    localparam int CNT_W       = ADDR_W + 1
) (
    input  logic                 clka,
    input  logic                 rsta,
    input  logic                 start_in,
    input  logic [ADDR_W-1:0]    base_in,
    input  logic [CNT_W-1:0]     count_in,
    output logic                 busy_out,
    output logic                 done_out,
    output logic [ADDR_W-1:0]    addra,
    output logic                 ena,
    output logic                 wea,
    output logic                 regcea,
    input  logic [RAM_WIDTH-1:0] douta,
    output logic [RAM_WIDTH-1:0] m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_tlast
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W  = $clog2(FIFO_DEPTH + READ_LATENCY + 3);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state;
    logic [ADDR_W-1:0]       cur_addr;
    logic [CNT_W-1:0]        issue_left;
    logic                    ena_last;
    logic [READ_LATENCY-1:0] tag_v;
    logic [READ_LATENCY-1:0] tag_l;

    logic [RAM_WIDTH-1:0]    fifo_data [FIFO_DEPTH];
    logic                    fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        wr_ptr;
    logic [FCNT_W-1:0]       fifo_count;

    logic                    push;
    logic                    push_last;
    logic                    pop;
    logic [OCC_W-1:0]        occupancy;
    logic                    issue_ok;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(RAM_DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign wea       = 1'b0;
    assign regcea    = tag_v[0];
    assign push      = tag_v[READ_LATENCY-1];
    assign push_last = tag_l[READ_LATENCY-1];
    assign m_tvalid  = (fifo_count != '0);
    assign m_tdata   = fifo_data[rd_ptr];
    assign m_tlast   = m_tvalid & fifo_last[rd_ptr];
    assign pop       = m_tvalid & m_tready;

    // Every read on the wire or in the tag pipe already owns a FIFO slot; a pop this cycle frees one.
    assign occupancy = OCC_W'(ena) + OCC_W'($countones(tag_v)) + OCC_W'(fifo_count);
    assign issue_ok  = (occupancy < (OCC_W'(FIFO_DEPTH) + OCC_W'(pop)));

    always_ff @(posedge clka) begin
        if (rsta) begin
            state      <= S_IDLE;
            busy_out   <= 1'b0;
            done_out   <= 1'b0;
            ena        <= 1'b0;
            ena_last   <= 1'b0;
            addra      <= '0;
            cur_addr   <= '0;
            issue_left <= '0;
            tag_v      <= '0;
            tag_l      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            tag_v <= (tag_v << 1) | READ_LATENCY'(ena);
            tag_l <= (tag_l << 1) | READ_LATENCY'(ena & ena_last);

            if (push) begin
                fifo_data[wr_ptr] <= douta;
                fifo_last[wr_ptr] <= push_last;
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            ena      <= 1'b0;
            done_out <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start_in) begin
                        busy_out <= 1'b1;
                        if (count_in == '0) begin
                            state <= S_DONE;
                        end else begin
                            ena        <= 1'b1;
                            ena_last   <= (count_in == CNT_W'(1));
                            addra      <= base_in;
                            cur_addr   <= addr_inc(base_in);
                            issue_left <= count_in - 1'b1;
                            state      <= (count_in == CNT_W'(1)) ? S_DRAIN : S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (issue_ok) begin
                        ena        <= 1'b1;
                        ena_last   <= (issue_left == CNT_W'(1));
                        addra      <= cur_addr;
                        cur_addr   <= addr_inc(cur_addr);
                        issue_left <= issue_left - 1'b1;
                        if (issue_left == CNT_W'(1)) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && m_tlast) begin
                        busy_out <= 1'b0;
                        done_out <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    // A zero-length request arrives here with no pulse yet and emits it one cycle later.
                    if (done_out) begin
                        state <= S_IDLE;
                    end else begin
                        busy_out <= 1'b0;
                        done_out <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb/tb_bram_stream_reader.sv - directed bench with a BRAM model and scoreboard for bram_stream_reader
module tb_bram_stream_reader;

    localparam int W  = 18;
    localparam int D  = 1024;
    localparam int AW = 10;
    localparam int CW = 11;

    logic          clka = 1'b0;
    logic          rsta;
    logic          start_in;
    logic [AW-1:0] base_in;
    logic [CW-1:0] count_in;
    logic          busy_out;
    logic          done_out;
    logic [AW-1:0] addra;
    logic          ena;
    logic          wea;
    logic          regcea;
    logic [W-1:0]  douta = '0;
    logic [W-1:0]  m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;

    always #5 clka = ~clka;

    bram_stream_reader dut (
        .clka     (clka),
        .rsta     (rsta),
        .start_in (start_in),
        .base_in  (base_in),
        .count_in (count_in),
        .busy_out (busy_out),
        .done_out (done_out),
        .addra    (addra),
        .ena      (ena),
        .wea      (wea),
        .regcea   (regcea),
        .douta    (douta),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast)
    );

    // Two-stage BRAM: array read on ena, output register loaded on regcea; contents equal the address.
    logic [W-1:0] mem [D];
    logic [W-1:0] ram_lat = '0;
    initial for (int i = 0; i < D; i++) mem[i] = W'(i);
    always @(posedge clka) begin
        if (ena)    ram_lat <= mem[addra];
        if (regcea) douta   <= ram_lat;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    logic [W:0] sb [$];

    task automatic push_expect(input int base, input int count);
        for (int i = 0; i < count; i++)
            sb.push_back({(i == count - 1), W'((base + i) % D)});
    endtask

    int         outstanding = 0;
    int         pops        = 0;
    logic       prev_ena    = 1'b0;
    logic       prev_stall  = 1'b0;
    logic [W:0] prev_beat   = '0;
    logic [W:0] expv;

    always @(negedge clka) begin
        if (rsta) begin
            outstanding = 0;
            prev_ena    = 1'b0;
            prev_stall  = 1'b0;
        end else begin
            if (regcea || prev_ena) chk("regcea_follows_ena", 32'(regcea), 32'(prev_ena));
            if (ena) begin
                outstanding++;
                chk("occupancy_le_4", 32'(outstanding <= 4), 32'd1);
            end
            if (prev_stall) begin
                chk("stall_valid_held", 32'(m_tvalid), 32'd1);
                chk("stall_beat_held", 32'({m_tlast, m_tdata}), 32'(prev_beat));
            end
            if (m_tvalid && m_tready) begin
                chk("beat_was_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    expv = sb.pop_front();
                    chk("beat_last_data", 32'({m_tlast, m_tdata}), 32'(expv));
                end
                outstanding--;
                pops++;
            end
            prev_ena   = ena;
            prev_stall = m_tvalid & !m_tready;
            prev_beat  = {m_tlast, m_tdata};
        end
    end

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic start_req(input int base, input int count);
        base_in  = AW'(base);
        count_in = CW'(count);
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, input string tag);
        int n = 0;
        while (!done_out && n < max_cycles) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done_out), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int p0;
        rsta     = 1'b1;
        start_in = 1'b0;
        base_in  = '0;
        count_in = '0;
        m_tready = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_done", 32'(done_out), 32'd0);
        chk("rst_ena", 32'(ena), 32'd0);
        chk("rst_regcea", 32'(regcea), 32'd0);
        chk("rst_addra", 32'(addra), 32'd0);
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tlast", 32'(m_tlast), 32'd0);
        chk("rst_tdata", 32'(m_tdata), 32'd0);
        chk("rst_wea", 32'(wea), 32'd0);
        rsta = 1'b0;
        tick();

        // Basic 8-word read with latency and contiguity checks.
        m_tready = 1'b1;
        push_expect(0, 8);
        start_req(0, 8);
        chk("t1_ena_T1", 32'(ena), 32'd1);
        chk("t1_addra_T1", 32'(addra), 32'd0);
        chk("t1_busy_T1", 32'(busy_out), 32'd1);
        tick();
        chk("t1_regcea_T2", 32'(regcea), 32'd1);
        tick();
        chk("t1_tvalid_T3", 32'(m_tvalid), 32'd0);
        tick();
        chk("t1_tvalid_T4", 32'(m_tvalid), 32'd1);
        chk("t1_tdata_T4", 32'(m_tdata), 32'd0);
        chk("t1_tlast_T4", 32'(m_tlast), 32'd0);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("t1_tvalid_run", 32'(m_tvalid), 32'd1);
            chk("t1_tdata_run", 32'(m_tdata), 32'(i));
            chk("t1_tlast_run", 32'(m_tlast), 32'(i == 7));
        end
        tick();
        chk("t1_done", 32'(done_out), 32'd1);
        chk("t1_busy_clear", 32'(busy_out), 32'd0);
        tick();
        chk("t1_done_one_cycle", 32'(done_out), 32'd0);
        chk("t1_sb_empty", 32'(sb.size()), 32'd0);

        // Address wrap at the top of the RAM.
        push_expect(1020, 8);
        start_req(1020, 8);
        chk("t2_addra_base", 32'(addra), 32'd1020);
        repeat (4) tick();
        chk("t2_ena_wrap", 32'(ena), 32'd1);
        chk("t2_addra_wrap", 32'(addra), 32'd0);
        wait_done(40, "t2");
        tick();
        chk("t2_sb_empty", 32'(sb.size()), 32'd0);

        // Random 30% backpressure.
        push_expect(100, 16);
        start_req(100, 16);
        n = 0;
        while (!done_out && n < 400) begin
            m_tready = ($urandom_range(0, 99) >= 30);
            tick();
            n++;
        end
        chk("t3_done_seen", 32'(done_out), 32'd1);
        m_tready = 1'b1;
        tick();
        chk("t3_sb_empty", 32'(sb.size()), 32'd0);

        // Zero-length request.
        start_req(5, 0);
        chk("t4_ena_T1", 32'(ena), 32'd0);
        chk("t4_tvalid_T1", 32'(m_tvalid), 32'd0);
        chk("t4_done_T1", 32'(done_out), 32'd0);
        tick();
        chk("t4_done_T2", 32'(done_out), 32'd1);
        chk("t4_ena_T2", 32'(ena), 32'd0);
        chk("t4_tvalid_T2", 32'(m_tvalid), 32'd0);
        tick();
        chk("t4_done_T3", 32'(done_out), 32'd0);

        // A second start while busy must be ignored.
        push_expect(200, 6);
        start_req(200, 6);
        tick();
        start_req(500, 3);
        wait_done(40, "t5");
        tick();
        chk("t5_sb_empty", 32'(sb.size()), 32'd0);
        repeat (4) tick();
        chk("t5_no_extra_beats", 32'(m_tvalid), 32'd0);
        chk("t5_idle", 32'(busy_out), 32'd0);

        // Reset mid-transfer with the fifth beat stalled.
        p0 = pops;
        push_expect(300, 10);
        start_req(300, 10);
        n = 0;
        while ((pops - p0) < 4 && n < 40) begin
            tick();
            n++;
        end
        m_tready = 1'b0;
        chk("t6_beat5_pending", 32'(m_tvalid), 32'd1);
        chk("t6_beat5_data", 32'(m_tdata), 32'd304);
        rsta = 1'b1;
        tick();
        rsta = 1'b0;
        sb.delete();
        chk("t6_rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("t6_rst_busy", 32'(busy_out), 32'd0);
        chk("t6_rst_done", 32'(done_out), 32'd0);
        chk("t6_rst_ena", 32'(ena), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t6_no_done", 32'(done_out), 32'd0);
            chk("t6_no_tvalid", 32'(m_tvalid), 32'd0);
        end
        m_tready = 1'b1;
        p0 = pops;
        push_expect(0, 2);
        start_req(0, 2);
        wait_done(40, "t6");
        chk("t6_beat_count", 32'(pops - p0), 32'd2);
        tick();
        chk("t6_sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
